// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: two-requester read arbiter for one latched-q ROM; ROM_ARB_RR_EN selects round-robin (else A priority); ports: clock/reset, reqA/reqB valid/addr/ready, rspA/rspB valid/data, romAddress/romData, busy
module rom_read_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int ROM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqA_valid,
  input  logic [ADDR_W-1:0] reqA_addr,
  output logic              reqA_ready,
  output logic              rspA_valid,
  output logic [DATA_W-1:0] rspA_data,
  input  logic              reqB_valid,
  input  logic [ADDR_W-1:0] reqB_addr,
  output logic              reqB_ready,
  output logic              rspB_valid,
  output logic [DATA_W-1:0] rspB_data,
  output logic [ADDR_W-1:0] romAddress,
  input  logic [DATA_W-1:0] romData,
  output logic              busy
);
  logic prio_a, gnt_a, gnt_b;
  logic [ADDR_W-1:0] addr_q;
  logic [ROM_LAT-1:0] pv, pid;
`ifdef ROM_ARB_RR_EN
  logic last_b;
  always_ff @(posedge clock or posedge reset)
    if (reset) last_b <= 1'b1;
    else if (gnt_a || gnt_b) last_b <= gnt_b;
  assign prio_a = last_b;
`else
  assign prio_a = 1'b1;
`endif
  always_comb begin
    gnt_a = !reset && reqA_valid && (!reqB_valid || prio_a);
    gnt_b = !reset && reqB_valid && !gnt_a;
    reqA_ready = gnt_a;
    reqB_ready = gnt_b;
    romAddress = gnt_a ? reqA_addr : gnt_b ? reqB_addr : addr_q;
    busy = |pv;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      addr_q <= '0;
      pv <= '0;
      pid <= '0;
      rspA_valid <= 1'b0;
      rspB_valid <= 1'b0;
      rspA_data <= '0;
      rspB_data <= '0;
    end else begin
      addr_q <= romAddress;
      pv[0] <= gnt_a || gnt_b;
      pid[0] <= gnt_b;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i] <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      rspA_valid <= pv[ROM_LAT-1] && !pid[ROM_LAT-1];
      rspB_valid <= pv[ROM_LAT-1] && pid[ROM_LAT-1];
      if (pv[ROM_LAT-1] && !pid[ROM_LAT-1]) rspA_data <= romData;
      if (pv[ROM_LAT-1] && pid[ROM_LAT-1]) rspB_data <= romData;
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: table, directed and random checks of rom_read_arbiter against a response-queue model
module tb_rom_read_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int LAT = 2;
`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic a_v = 1'b0, b_v = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic ra, rb, va, vb, busy;
  logic [DW-1:0] da, db;
  logic [DW-1:0] rom_data = '0;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] rom_a_q = '0;
  int checks = 0, errors = 0;
  always #10 clock = ~clock;
  rom_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .reqA_valid(a_v), .reqA_addr(a_addr), .reqA_ready(ra), .rspA_valid(va), .rspA_data(da),
    .reqB_valid(b_v), .reqB_addr(b_addr), .reqB_ready(rb), .rspB_valid(vb), .rspB_data(db),
    .romAddress(rom_addr), .romData(rom_data), .busy(busy)
  );
  always @(posedge clock) begin
    rom_a_q <= rom_addr;
    rom_data <= rom_a_q[7:0] ^ 8'h5A;
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {int due; bit id; logic [7:0] d;} rsp_t;
  rsp_t q[$];
  int cyc = 0;
  bit m_last_b = 1'b1, m_ga = 1'b0, m_gb = 1'b0, m_xa = 1'b0, m_xb = 1'b0;
  logic [AW-1:0] m_hold = '0;
  logic [7:0] m_da = '0, m_db = '0;
  function automatic bit win_a();
    return a_v && (!b_v || !RR || m_last_b);
  endfunction
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_last_b = 1'b1;
      m_hold = '0;
      m_da = '0;
      m_db = '0;
      m_ga = 1'b0;
      m_gb = 1'b0;
      m_xa = 1'b0;
      m_xb = 1'b0;
    end else begin
      cyc++;
      m_xa = 1'b0;
      m_xb = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].id) begin m_xb = 1'b1; m_db = q[0].d; end
        else begin m_xa = 1'b1; m_da = q[0].d; end
        void'(q.pop_front());
      end
      m_ga = win_a();
      m_gb = b_v && !m_ga;
      if (m_ga || m_gb) begin
        q.push_back('{due: cyc + LAT, id: m_gb, d: (m_gb ? b_addr[7:0] : a_addr[7:0]) ^ 8'h5A});
        m_hold = m_gb ? b_addr : a_addr;
        m_last_b = m_gb;
      end
    end
  end
  always @(negedge clock) begin
    bit ea, eb;
    ea = !reset && win_a();
    eb = !reset && b_v && !ea;
    chk("readyA", ra, ea);
    chk("readyB", rb, eb);
    chk("romAddress", rom_addr, ea ? a_addr : eb ? b_addr : m_hold);
    chk("rspA_valid", va, m_xa);
    chk("rspB_valid", vb, m_xb);
    chk("rspA_data", da, m_da);
    chk("rspB_data", db, m_db);
    chk("busy", busy, q.size() > 0);
    chk("rsp_exclusive", va && vb, 0);
  end
  task automatic step(bit av, logic [AW-1:0] aa, bit bv, logic [AW-1:0] ba);
    @(posedge clock);
    #1;
    a_v = av; a_addr = aa; b_v = bv; b_addr = ba;
    @(negedge clock);
  endtask
  typedef struct {bit va, vb, ra, rb; logic [AW-1:0] rom;} vec_t;
  function automatic vec_t mk(int va_i, int vb_i, int ra_i, int rb_i, int rom_i);
    vec_t v;
    v.va = va_i[0]; v.vb = vb_i[0]; v.ra = ra_i[0]; v.rb = rb_i[0]; v.rom = rom_i[AW-1:0];
    return v;
  endfunction
  vec_t tbl[8];
  initial begin
    int busy_n, pulse_k, na, nb, gb;
    logic [7:0] pulse_d;
    tbl[0] = mk(1, 1, 1, 0, 'h100);
    tbl[1] = mk(1, 1, int'(!RR), int'(RR), RR ? 'h201 : 'h101);
    tbl[2] = mk(0, 1, 0, 1, 'h202);
    tbl[3] = mk(1, 1, 1, 0, 'h103);
    tbl[4] = mk(1, 0, 1, 0, 'h104);
    tbl[5] = mk(0, 0, 0, 0, 'h104);
    tbl[6] = mk(1, 1, int'(!RR), int'(RR), RR ? 'h206 : 'h106);
    tbl[7] = mk(0, 0, 0, 0, RR ? 'h206 : 'h106);
    #5;
    chk("reset_busy", busy, 0);
    chk("reset_romAddress", rom_addr, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].va, AW'(32'h100 + i), tbl[i].vb, AW'(32'h200 + i));
      chk($sformatf("tbl%0d_readyA", i), ra, tbl[i].ra);
      chk($sformatf("tbl%0d_readyB", i), rb, tbl[i].rb);
      chk($sformatf("tbl%0d_romAddress", i), rom_addr, tbl[i].rom);
    end
    repeat (3) step(0, '0, 0, '0);
    step(1, 'h010, 0, '0);
    chk("a_alone_ready", ra, 1);
    busy_n = 0; pulse_k = -1; pulse_d = '0;
    for (int k = 0; k < 5; k++) begin
      step(0, '0, 0, '0);
      if (busy) busy_n++;
      if (va) begin pulse_k = k; pulse_d = da; end
    end
    chk("a_alone_busy_cycles", busy_n, 2);
    chk("a_alone_rsp_cycle", pulse_k, 2);
    chk("a_alone_rsp_data", pulse_d, 8'h4A);
    na = 0; nb = 0; gb = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) step(1, 'h001, 1, 'h002); else step(0, '0, 0, '0);
      if (rb) gb++;
      if (va) begin na++; chk("contend_dataA", da, 8'h5B); end
      if (vb) begin nb++; chk("contend_dataB", db, 8'h58); end
    end
    chk("contend_countA", na, RR ? 4 : 8);
    chk("contend_countB", nb, RR ? 4 : 0);
    chk("contend_grantsB", gb, RR ? 4 : 0);
    step(1, 'h7FF, 0, '0);
    step(1, 'h000, 0, '0);
    step(1, 'h3A5, 0, '0);
    step(0, '0, 0, '0);
    chk("b2b_v0", va, 1); chk("b2b_d0", da, 8'hA5);
    step(0, '0, 0, '0);
    chk("b2b_v1", va, 1); chk("b2b_d1", da, 8'h5A);
    step(0, '0, 0, '0);
    chk("b2b_v2", va, 1); chk("b2b_d2", da, 8'hFF);
    step(0, '0, 0, 'h055);
    step(0, '0, 1, 'h055);
    chk("pre_reset_readyB", rb, 1);
    step(0, '0, 0, '0);
    #1 reset = 1'b1;
    #1 chk("reset_async_busy", busy, 0);
    a_v = 1'b1; b_v = 1'b1;
    @(negedge clock);
    chk("reset_readyA", ra, 0);
    chk("reset_readyB", rb, 0);
    @(posedge clock);
    #1 reset = 1'b0; a_v = 1'b0; b_v = 1'b0;
    nb = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, '0, 0, '0);
      if (vb) nb++;
    end
    chk("discarded_rspB", nb, 0);
    step(1, 'h011, 1, 'h022);
    chk("post_reset_winA", ra, 1);
    chk("post_reset_loseB", rb, 0);
    step(0, '0, 0, '0);
    repeat (3) step(0, '0, 0, '0);
    step(1, 'h123, 0, '0);
    repeat (10) step(0, '0, 0, '0);
    chk("hold_romAddress", rom_addr, 'h123);
    chk("hold_readyA", ra, 0);
    chk("hold_readyB", rb, 0);
    chk("hold_busy", busy, 0);
    for (int k = 0; k < 400; k++) begin
      @(posedge clock);
      #1;
      if (!a_v || m_ga) begin a_v = ($urandom_range(0, 3) != 0); a_addr = AW'($urandom); end
      if (!b_v || m_gb) begin b_v = ($urandom_range(0, 2) != 0); b_addr = AW'($urandom); end
    end
    repeat (6) step(0, '0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
